// File: rtl/afifo_rd_stream_bridge.sv
// Read-domain consumer for the async FIFO: pops FWFT words into a 2-entry
// registered valid/ready buffer, with a flush mode that drains and discards.
module afifo_rd_stream_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      pop_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic                  push, pop, drop, flush_take;

  // rinc depends only on state, occupancy and rempty, never on out_ready.
  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    case (state)
      IDLE: begin
        if (flush)   state_nxt = FLUSH;
        else if (en) state_nxt = RUN;
      end
      RUN: begin
        rinc = !rempty && (occ != 2'd2);
        if (flush)    state_nxt = FLUSH;
        else if (!en) state_nxt = IDLE;
      end
      FLUSH: begin
        rinc = !rempty;
        if (rempty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rrst) rinc = 1'b0;
  end

  assign push       = rinc && (state == RUN);
  assign drop       = rinc && (state == FLUSH);
  assign pop        = out_valid && out_ready;
  assign flush_take = flush && (state != FLUSH);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= IDLE;
      occ        <= '0;
      ent0       <= '0;
      ent1       <= '0;
      flush_done <= 1'b0;
      pop_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == FLUSH) && rempty;
      pop_cnt    <= pop_cnt + CNT_W'(push);
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);

      if (flush_take) begin
        occ <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (occ == 2'd0) ent0 <= rdata;
            else             ent1 <= rdata;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            ent0 <= ent1;
            occ  <= occ - 2'd1;
          end
          // push implies occ<2 and pop implies occ>0, so occ is 1 here
          2'b11: ent0 <= rdata;
          default: ;
        endcase
      end
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = ent0;
  assign busy      = (state != IDLE) || (occ != 2'd0);

endmodule

// File: tb/tb_afifo_rd_stream_bridge.sv
// Directed bench: behavioural FWFT FIFO feeding the bridge, scoreboard of
// expected stream words, plus a CNT_W=2 instance for counter wrap/saturation.
module tb_afifo_rd_stream_bridge;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst, rempty, rinc, en, flush, out_valid, out_ready, flush_done, busy;
  logic [DW-1:0] rdata, out_data;
  logic [15:0]   pop_cnt, drop_cnt;

  logic          rempty2, rinc2, en2, flush2, out_valid2, out_ready2, flush_done2, busy2;
  logic [DW-1:0] rdata2, out_data2;
  logic [1:0]    pop_cnt2, drop_cnt2;

  always #5 rclk = ~rclk;

  afifo_rd_stream_bridge #(.DATA_WIDTH(DW), .CNT_W(16)) u_dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .en(en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush_done(flush_done), .busy(busy),
    .pop_cnt(pop_cnt), .drop_cnt(drop_cnt));

  afifo_rd_stream_bridge #(.DATA_WIDTH(DW), .CNT_W(2)) u_small (
    .rclk(rclk), .rrst(rrst), .rdata(rdata2), .rempty(rempty2), .rinc(rinc2),
    .en(en2), .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .flush_done(flush_done2), .busy(busy2),
    .pop_cnt(pop_cnt2), .drop_cnt(drop_cnt2));

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int cyc_no = 0;
  int rinc_n, rinc_first, rinc_last, hs_n, hs_first, hs_last, fd_n, fd_at, r2_n;
  logic fd_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [DW-1:0] w, input bit to_stream);
    fifo_q.push_back(w);
    if (to_stream) exp_q.push_back(w);
    fifo_drive();
  endtask

  task automatic clr_track();
    rinc_n = 0; rinc_first = -1; rinc_last = -1;
    hs_n = 0; hs_first = -1; hs_last = -1;
    fd_n = 0; fd_at = -1; fd_busy = 1'bx;
  endtask

  // Observe on the falling edge, then apply FIFO pops just after the rising edge.
  task automatic step();
    logic took;
    @(negedge rclk);
    cyc_no++;
    chk("rinc_when_empty", rinc & rempty, 32'd0);
    chk("rinc2_when_empty", rinc2 & rempty2, 32'd0);
    if (rinc) begin
      if (rinc_n == 0) rinc_first = cyc_no;
      rinc_last = cyc_no;
      rinc_n++;
    end
    if (out_valid && out_ready) begin
      if (hs_n == 0) hs_first = cyc_no;
      hs_last = cyc_no;
      hs_n++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra_word: observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) chk("sb_data", out_data, exp_q.pop_front());
    end
    if (flush_done) begin
      fd_n++;
      fd_at   = cyc_no;
      fd_busy = busy;
    end
    if (rinc2) r2_n++;
    took = rinc;
    @(posedge rclk);
    #1;
    if (took && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_drive();
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flush_done", flush_done, 32'd0);
    chk("rst_pop_cnt", pop_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_busy", busy, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rrst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rempty2 = 1'b1; rdata2 = 8'h5a; en2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b1;
    r2_n = 0;
    fifo_drive();
    clr_track();
    step(); step();
    chk("rst_rinc", rinc_n, 32'd0);
    chk_reset_vals();
    rrst = 1'b0;

    // Basic streaming with sink always ready
    load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
    en = 1'b1; out_ready = 1'b1;
    clr_track();
    repeat (7) step();
    chk("t1_rinc_n", rinc_n, 32'd3);
    chk("t1_rinc_consec", rinc_last - rinc_first, 32'd2);
    chk("t1_hs_n", hs_n, 32'd3);
    chk("t1_latency", hs_first, rinc_first + 1);
    chk("t1_throughput", hs_last - hs_first, 32'd2);
    chk("t1_pop_cnt", pop_cnt, 32'd3);
    chk("t1_exp_empty", exp_q.size(), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    load(8'ha0, 1); load(8'ha1, 1); load(8'ha2, 1); load(8'ha3, 1); load(8'ha4, 1);
    clr_track();
    repeat (3) step();
    chk("t2_valid", out_valid, 32'd1);
    chk("t2_head_a", out_data, 32'h0a0);
    repeat (3) step();
    chk("t2_rinc_n", rinc_n, 32'd2);
    chk("t2_head_b", out_data, 32'h0a0);
    chk("t2_fifo_left", fifo_q.size(), 32'd3);
    out_ready = 1'b1;
    clr_track();
    repeat (8) step();
    chk("t2_hs_n", hs_n, 32'd5);
    chk("t2_exp_empty", exp_q.size(), 32'd0);
    chk("t2_pop_cnt", pop_cnt, 32'd8);

    // Flush with a full buffer
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hb0 + 8'(i), 0);
    clr_track();
    repeat (4) step();
    chk("t3_fifo_left", fifo_q.size(), 32'd4);
    chk("t3_full_valid", out_valid, 32'd1);
    flush = 1'b1; en = 1'b0;
    clr_track();
    step();
    flush = 1'b0;
    chk("t3_cleared", out_valid, 32'd0);
    repeat (7) step();
    chk("t3_rinc_n", rinc_n, 32'd4);
    chk("t3_drop_cnt", drop_cnt, 32'd4);
    chk("t3_pop_cnt", pop_cnt, 32'd10);
    chk("t3_fd_n", fd_n, 32'd1);
    chk("t3_fd_timing", fd_at, rinc_last + 2);
    chk("t3_busy", busy, 32'd0);
    out_ready = 1'b1;

    // flush and en together from IDLE
    load(8'he0, 0); load(8'he1, 0);
    en = 1'b1; flush = 1'b1;
    clr_track();
    step();
    flush = 1'b0;
    g = 0;
    while (fd_n == 0 && g < 12) begin step(); g++; end
    chk("t4_fd_seen", fd_n, 32'd1);
    chk("t4_drop_cnt", drop_cnt, 32'd6);
    chk("t4_no_words", hs_n, 32'd0);
    chk("t4_idle_at_fd", fd_busy, 32'd0);
    chk("t4_run_after", busy, 32'd1);
    chk("t4_pop_cnt", pop_cnt, 32'd10);
    en = 1'b0;
    step();

    // en dropped with the buffer full
    out_ready = 1'b0; en = 1'b1;
    load(8'hc0, 1); load(8'hc1, 1); load(8'hc2, 0);
    repeat (5) step();
    chk("t5_valid", out_valid, 32'd1);
    chk("t5_fifo_left", fifo_q.size(), 32'd1);
    en = 1'b0;
    clr_track();
    step();
    out_ready = 1'b1;
    repeat (4) step();
    chk("t5_rinc_n", rinc_n, 32'd0);
    chk("t5_hs_n", hs_n, 32'd2);
    chk("t5_busy", busy, 32'd0);
    chk("t5_exp_empty", exp_q.size(), 32'd0);
    chk("t5_pop_cnt", pop_cnt, 32'd12);

    // Reset in the middle of a flush
    load(8'hd0, 0); load(8'hd1, 0); load(8'hd2, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t6_fifo_mid", fifo_q.size(), 32'd3);
    clr_track();
    rrst = 1'b1;
    step();
    chk("t6_rinc_in_rst", rinc_n, 32'd0);
    chk_reset_vals();
    step();
    rrst = 1'b0;
    repeat (4) step();
    chk("t6_no_fd", fd_n, 32'd0);
    chk("t6_drop_cnt", drop_cnt, 32'd0);
    chk("t6_fifo_kept", fifo_q.size(), 32'd3);
    chk("t6_busy", busy, 32'd0);

    // CNT_W=2: pop counter wraps, drop counter saturates
    rempty2 = 1'b0; en2 = 1'b1; r2_n = 0;
    g = 0;
    while (r2_n < 5 && g < 20) begin step(); g++; end
    rempty2 = 1'b1; en2 = 1'b0;
    step();
    chk("t7_pops", r2_n, 32'd5);
    chk("t7_pop_wrap", pop_cnt2, 32'd1);
    rempty2 = 1'b0; flush2 = 1'b1; r2_n = 0;
    step();
    flush2 = 1'b0;
    repeat (5) step();
    rempty2 = 1'b1;
    step();
    chk("t7_drops", r2_n, 32'd5);
    chk("t7_drop_sat", drop_cnt2, 32'd3);
    chk("t7_fd", flush_done2, 32'd1);

    chk("final_exp_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
